mem_arbiter_rr: RTL

- Round-robin arbiter that lets NR_PORTS requesters share one memory port using the core's req/gnt/rvalid memory protocol.
- Each requester port is a slave-side memory interface. The arbiter drives a single master-side request towards memory and routes each in-order response back to the requester that issued it.
- Sits between core-side agents (fetch, load/store, PTW) and a single memory or cache port.

---
 rtl/mem_arbiter_rr_if.sv | 36 +++
 rtl/mem_arbiter_rr.sv | 79 +++++++
 2 files changed

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester-side and memory-side req/gnt/rvalid bundle for the round-robin arbiter
interface mem_arbiter_rr_if #(
  parameter int NR_PORTS     = 3,
  parameter int ADDRESS_SIZE = 64,
  parameter int DATA_WIDTH   = 64
);
  logic [NR_PORTS*ADDRESS_SIZE-1:0]   req_address_i;
  logic [NR_PORTS*DATA_WIDTH-1:0]     req_wdata_i;
  logic [NR_PORTS-1:0]                req_we_i;
  logic [NR_PORTS*DATA_WIDTH/8-1:0]   req_be_i;
  logic [NR_PORTS-1:0]                req_valid_i;
  logic [NR_PORTS-1:0]                req_gnt_o;
  logic [NR_PORTS-1:0]                req_rvalid_o;
  logic [DATA_WIDTH-1:0]              req_rdata_o;
  logic [ADDRESS_SIZE-1:0]            mem_address_o;
  logic [DATA_WIDTH-1:0]              mem_wdata_o;
  logic                               mem_we_o;
  logic [DATA_WIDTH/8-1:0]            mem_be_o;
  logic                               mem_req_o;
  logic                               mem_gnt_i;
  logic                               mem_rvalid_i;
  logic [DATA_WIDTH-1:0]              mem_rdata_i;
  logic                               unexpected_rvalid_o;
  modport slave (
    input  req_address_i, req_wdata_i, req_we_i, req_be_i, req_valid_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_gnt_o, req_rvalid_o, req_rdata_o, mem_address_o, mem_wdata_o,
           mem_we_o, mem_be_o, mem_req_o, unexpected_rvalid_o
  );
  modport master (
    output req_address_i, req_wdata_i, req_we_i, req_be_i, req_valid_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_gnt_o, req_rvalid_o, req_rdata_o, mem_address_o, mem_wdata_o,
           mem_we_o, mem_be_o, mem_req_o, unexpected_rvalid_o
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one req/gnt/rvalid memory port among NR_PORTS requesters
module mem_arbiter_rr #(
  parameter int NR_PORTS        = 3,
  parameter int ADDRESS_SIZE    = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  mem_arbiter_rr_if.slave bus
);
  localparam int PW = $clog2(NR_PORTS);
  localparam int AW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic {ARB, HOLD} state_t;
  state_t          state;
  logic [PW-1:0]   rr_ptr, hold_idx, rr_sel, sel, head;
  logic [PW-1:0]   fifo [MAX_OUTSTANDING];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            found, any_valid, mem_req, gnt, pop;
  int              idx;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    rr_sel = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NR_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NR_PORTS;
      if (!found && bus.req_valid_i[idx]) begin
        rr_sel = PW'(idx);
        found  = 1'b1;
      end
    end
  end
  // a stalled request stays locked to its port so payload cannot change under the memory
  assign sel       = (state == HOLD) ? hold_idx : rr_sel;
  assign any_valid = (state == HOLD) ? bus.req_valid_i[hold_idx] : |bus.req_valid_i;
  assign mem_req   = rst_ni && any_valid && (count < CW'(MAX_OUTSTANDING));
  assign gnt       = mem_req && bus.mem_gnt_i;
  assign pop       = rst_ni && bus.mem_rvalid_i && (count != '0);
  assign head      = fifo[rd_ptr];
  assign bus.mem_req_o           = mem_req;
  assign bus.mem_address_o       = mem_req ? bus.req_address_i[int'(sel)*ADDRESS_SIZE +: ADDRESS_SIZE] : '0;
  assign bus.mem_wdata_o         = mem_req ? bus.req_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.mem_be_o            = mem_req ? bus.req_be_i[int'(sel)*BW +: BW] : '0;
  assign bus.mem_we_o            = mem_req && bus.req_we_i[sel];
  assign bus.req_gnt_o           = gnt ? NR_PORTS'(1) << sel : '0;
  assign bus.req_rvalid_o        = pop ? NR_PORTS'(1) << head : '0;
  assign bus.req_rdata_o         = rst_ni ? bus.mem_rdata_i : '0;
  assign bus.unexpected_rvalid_o = rst_ni && bus.mem_rvalid_i && (count == '0);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ARB;
      rr_ptr   <= '0;
      hold_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (gnt) begin
        fifo[wr_ptr] <= sel;
        wr_ptr       <= inc(wr_ptr);
        rr_ptr       <= (sel == PW'(NR_PORTS - 1)) ? '0 : sel + 1'b1;
        state        <= ARB;
      end else if (state == ARB && mem_req) begin
        state    <= HOLD;
        hold_idx <= sel;
      end else if (state == HOLD && !bus.req_valid_i[hold_idx]) begin
        state <= ARB;
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(gnt) - CW'(pop);
    end
  end
endmodule
